decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I instruction-decode pipeline stage.
//  - Decodes LANES instructions per beat into packed control bundles: the same fields as the single-lane
//    combinational controller, plus an illegal flag.
//  - Sits between fetch and issue. Valid/ready handshake with a 2-entry skid buffer, flush, and a decoded-instruction counter.
// PARAMETERS
//  LANES     1   instructions per beat (1..4), lane 0 = oldest
//  CNT_W     32  width of decoded-instruction counter
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           asynchronous active-high reset
//  flush         in   1           discard all buffered and incoming beats
//  in_valid      in   1           fetch beat valid
//  in_ready      out  1           stage can accept a beat
//  in_inst       in   LANES*32    instructions, lane i at [32i+31:32i]
//  in_pc         in   LANES*32    PCs, same packing
//  in_lane_vld   in   LANES       per-lane valid mask within beat
//  out_valid     out  1           decoded beat valid
//  out_ready     in   1           issue accepts beat
//  out_ctrl      out  LANES*CTRL_W  control bundle per lane (CTRL_W from package)
//  out_inst      out  LANES*32    registered instructions
//  out_pc        out  LANES*32    registered PCs
//  out_lane_vld  out  LANES       registered lane mask
//  dec_count     out  CNT_W       total lanes delivered downstream
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, dec_count=0, skid empty; out_ctrl/out_inst/out_pc/out_lane_vld=0.
//  - Latency: beat accepted at edge N (in_valid&in_ready) appears with out_valid=1 after edge N.
//  - Output register holds while out_valid&!out_ready; payload is stable and out_valid cannot drop.
//  - Skid: in_ready = !skid_full, registered.
//    - Accept while the output is stalled: the beat goes to the skid entry.
//    - On the next out handshake the skid entry moves to the output register; in_ready rises on the following edge.
//    - Full throughput when out_ready is held 1.
//  - Decode is combinational per lane and registered with the payload. Field values per opcode[6:2]:
//    - OP 0x0C: reg_write, ALU op from funct3 / inst[30].
//    - OP-IMM 0x04: alu_src1. SRA only when funct3=5 and inst[30]=1.
//    - LOAD 0x00: mem_to_reg, ADD. LB/LH/LW/LBU/LHU set ls_byte/half/load_unsigned.
//    - STORE 0x08: mem_write. SB/SH/SW.
//    - BRANCH 0x18: one-hot br[5:0] = {bgeu,bltu,bge,blt,bne,beq}.
//    - LUI 0x0D: SRC1, u_type. AUIPC 0x05: alu_src0, alu_src1, u_type, ADD.
//    - JAL 0x1B / JALR 0x19: reg_write plus jal/jalr.
//    - SYSTEM 0x1C, funct3=0: ecall/ebreak/mret. jalr stays 0 for SYSTEM.
//  - illegal=1 with all side-effect bits 0 (reg_write, mem_write, br, jal, jalr, ecall, ebreak, mret) for any of:
//    - inst[1:0]!=2'b11;
//    - unlisted opcode;
//    - load funct3 3/6/7; store funct3>2; branch funct3 2/3;
//    - SYSTEM with an unlisted encoding.
//  - Lanes with in_lane_vld=0 are decoded but their bundle is forced to all-zero (illegal=0).
//  - flush: at the edge, out_valid=0, skid cleared, in_ready=1. A beat presented that same cycle is dropped.
//    Flush has priority over every handshake.
//  - dec_count += popcount(out_lane_vld) on each out handshake. Wraps modulo 2^CNT_W. Not incremented on flush.
//  - rst asserted mid-stall: all state returns to reset values immediately (asynchronous).
// CONFIGURATION
//  - RV32M_DECODE_EN defined: OP with funct7=7'b0000001 decodes to alu_op
//    MUL=5'b10011, MULH=10100, MULHSU=10101, MULHU=10110, DIV=10111, DIVU=11000, REM=11001, REMU=11010, with reg_write.
//  - Not defined: that encoding sets illegal=1.
//  - OP with any other funct7 except 0000000/0100000 is illegal in both builds.
// STRUCTURE
//  - Package rv_ctrl_pkg: ALU op localparams, opcode localparams, ctrl_t bundle layout and CTRL_W=27.
//    Bit 26 illegal, [25:21] alu_op, then single-bit fields in controller order.
//  - Sub-module rv32_decode_lane: combinational inst->ctrl_t, instantiated LANES times in a generate loop.
//  - This module: skid buffer, output register, flush, counter.
// TESTING
//  - ADD x3,x1,x2 (0x002081B3), LANES=1, out_ready=1 -> next cycle out_valid=1, alu_op=00000, reg_write=1, illegal=0.
//  - Back-to-back 3 beats; out_ready=0 for 2 cycles after the first
//    -> beat 2 held in skid, in_ready=0 for 1 cycle, order preserved, no loss, no duplication.
//  - flush with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, dec_count unchanged.
//  - Encodings 0x00000000, 0x0000307F (lw x0 malformed), 0x00002063 (branch funct3=2) -> illegal=1, reg_write=0, br=0.
//  - 0x022081B3 (MUL): with RV32M_DECODE_EN -> alu_op=10011, reg_write=1; without -> illegal=1.
//  - LANES=2, in_lane_vld=2'b01, 5 handshakes -> dec_count=5.
//    Lane 1 bundle all-zero. rst pulsed mid-stall -> out_valid=0 asynchronously.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I decode encodings and the packed per-lane control bundle.
// No logic of its own; used by rv32_decode_lane and decode_stage.
// Bundle layout: bit 26 illegal, [25:21] alu_op, then single-bit fields.
package rv_ctrl_pkg;

  localparam int CTRL_W = 27;

  // ALU operations
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_SLL    = 5'b00010;
  localparam logic [4:0] ALU_SLT    = 5'b00011;
  localparam logic [4:0] ALU_SLTU   = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_OR     = 5'b01000;
  localparam logic [4:0] ALU_AND    = 5'b01001;
  localparam logic [4:0] ALU_SRC1   = 5'b01010;
  localparam logic [4:0] ALU_MUL    = 5'b10011;
  localparam logic [4:0] ALU_MULH   = 5'b10100;
  localparam logic [4:0] ALU_MULHSU = 5'b10101;
  localparam logic [4:0] ALU_MULHU  = 5'b10110;
  localparam logic [4:0] ALU_DIV    = 5'b10111;
  localparam logic [4:0] ALU_DIVU   = 5'b11000;
  localparam logic [4:0] ALU_REM    = 5'b11001;
  localparam logic [4:0] ALU_REMU   = 5'b11010;

  // Major opcodes, inst[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'h00;
  localparam logic [4:0] OPC_OPIMM  = 5'h04;
  localparam logic [4:0] OPC_AUIPC  = 5'h05;
  localparam logic [4:0] OPC_STORE  = 5'h08;
  localparam logic [4:0] OPC_OP     = 5'h0C;
  localparam logic [4:0] OPC_LUI    = 5'h0D;
  localparam logic [4:0] OPC_BRANCH = 5'h18;
  localparam logic [4:0] OPC_JALR   = 5'h19;
  localparam logic [4:0] OPC_JAL    = 5'h1B;
  localparam logic [4:0] OPC_SYSTEM = 5'h1C;

  typedef struct packed {
    logic       illegal;
    logic [4:0] alu_op;
    logic       reg_write;
    logic       alu_src0;
    logic       alu_src1;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       ls_byte;
    logic       ls_half;
    logic       load_unsigned;
    logic       u_type;
    logic [5:0] br;      // {bgeu,bltu,bge,blt,bne,beq}
    logic       jal;
    logic       jalr;
    logic       ecall;
    logic       ebreak;
    logic       mret;
  } ctrl_t;

  // Integer ALU op from funct3; alt selects SUB/SRA where it applies.
  function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_from_funct3 = ALU_ADD;
    case (f3)
      3'd0: alu_from_funct3 = alt ? ALU_SUB : ALU_ADD;
      3'd1: alu_from_funct3 = ALU_SLL;
      3'd2: alu_from_funct3 = ALU_SLT;
      3'd3: alu_from_funct3 = ALU_SLTU;
      3'd4: alu_from_funct3 = ALU_XOR;
      3'd5: alu_from_funct3 = alt ? ALU_SRA : ALU_SRL;
      3'd6: alu_from_funct3 = ALU_OR;
      default: alu_from_funct3 = ALU_AND;
    endcase
  endfunction

  // Multiply/divide ALU op from funct3.
  function automatic logic [4:0] alu_m_op(input logic [2:0] f3);
    alu_m_op = ALU_MUL;
    case (f3)
      3'd0: alu_m_op = ALU_MUL;
      3'd1: alu_m_op = ALU_MULH;
      3'd2: alu_m_op = ALU_MULHSU;
      3'd3: alu_m_op = ALU_MULHU;
      3'd4: alu_m_op = ALU_DIV;
      3'd5: alu_m_op = ALU_DIVU;
      3'd6: alu_m_op = ALU_REM;
      default: alu_m_op = ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/rv32_decode_lane.sv
// Purpose: combinational RV32I decode of one instruction into a ctrl_t bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; RV32M_DECODE_EN enables the OP funct7=0000001 encodings.
module rv32_decode_lane
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl
);

  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;
  ctrl_t      dec;

  assign opc = inst[6:2];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  // Decode fields; any illegal encoding collapses the bundle to just the illegal flag.
  always_comb begin
    dec  = '0;
    ill  = 1'b0;
    ctrl = '0;
    if (inst[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        OPC_OP: begin
          if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
            dec.reg_write = 1'b1;
            dec.alu_op    = alu_from_funct3(f3, inst[30]);
          end
`ifdef RV32M_DECODE_EN
          else if (f7 == 7'b0000001) begin
            dec.reg_write = 1'b1;
            dec.alu_op    = alu_m_op(f3);
          end
`endif
          else begin
            ill = 1'b1;
          end
        end
        OPC_OPIMM: begin
          dec.reg_write = 1'b1;
          dec.alu_src1  = 1'b1;
          dec.alu_op    = alu_from_funct3(f3, inst[30] & (f3 == 3'd5));
        end
        OPC_LOAD: begin
          dec.reg_write  = 1'b1;
          dec.alu_src1   = 1'b1;
          dec.mem_read   = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.alu_op     = ALU_ADD;
          case (f3)
            3'd0: dec.ls_byte = 1'b1;
            3'd1: dec.ls_half = 1'b1;
            3'd2: begin end
            3'd4: begin dec.ls_byte = 1'b1; dec.load_unsigned = 1'b1; end
            3'd5: begin dec.ls_half = 1'b1; dec.load_unsigned = 1'b1; end
            default: ill = 1'b1;
          endcase
        end
        OPC_STORE: begin
          dec.mem_write = 1'b1;
          dec.alu_src1  = 1'b1;
          dec.alu_op    = ALU_ADD;
          case (f3)
            3'd0: dec.ls_byte = 1'b1;
            3'd1: dec.ls_half = 1'b1;
            3'd2: begin end
            default: ill = 1'b1;
          endcase
        end
        OPC_BRANCH: begin
          case (f3)
            3'd0: dec.br = 6'b000001;
            3'd1: dec.br = 6'b000010;
            3'd4: dec.br = 6'b000100;
            3'd5: dec.br = 6'b001000;
            3'd6: dec.br = 6'b010000;
            3'd7: dec.br = 6'b100000;
            default: ill = 1'b1;
          endcase
        end
        OPC_LUI: begin
          dec.reg_write = 1'b1;
          dec.alu_src1  = 1'b1;
          dec.u_type    = 1'b1;
          dec.alu_op    = ALU_SRC1;
        end
        OPC_AUIPC: begin
          dec.reg_write = 1'b1;
          dec.alu_src0  = 1'b1;
          dec.alu_src1  = 1'b1;
          dec.u_type    = 1'b1;
          dec.alu_op    = ALU_ADD;
        end
        OPC_JAL: begin
          dec.reg_write = 1'b1;
          dec.jal       = 1'b1;
        end
        OPC_JALR: begin
          dec.reg_write = 1'b1;
          dec.jalr      = 1'b1;
        end
        OPC_SYSTEM: begin
          if (f3 == 3'd0 && inst[19:7] == 13'd0) begin
            case (inst[31:20])
              12'h000: dec.ecall  = 1'b1;
              12'h001: dec.ebreak = 1'b1;
              12'h302: dec.mret   = 1'b1;
              default: ill = 1'b1;
            endcase
          end else begin
            ill = 1'b1;
          end
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      ctrl.illegal = 1'b1;
    end else begin
      ctrl = dec;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Purpose: registered LANES-wide RV32I decode stage with 2-entry skid, flush and lane counter.
// Latency: 1 cycle from input handshake to out_valid.
// Backpressure: in_ready = !skid_full (registered); RV32M_DECODE_EN enables M-extension decode.
module decode_stage
  import rv_ctrl_pkg::*;
#(
  parameter int LANES = 1,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*32-1:0]     in_inst,
  input  logic [LANES*32-1:0]     in_pc,
  input  logic [LANES-1:0]        in_lane_vld,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*CTRL_W-1:0] out_ctrl,
  output logic [LANES*32-1:0]     out_inst,
  output logic [LANES*32-1:0]     out_pc,
  output logic [LANES-1:0]        out_lane_vld,
  output logic [CNT_W-1:0]        dec_count
);

  logic [LANES*CTRL_W-1:0] in_ctrl;
  logic                    skid_vld;
  logic [LANES*CTRL_W-1:0] skid_ctrl;
  logic [LANES*32-1:0]     skid_inst;
  logic [LANES*32-1:0]     skid_pc;
  logic [LANES-1:0]        skid_lane_vld;
  logic                    accept;
  logic                    out_free;
  logic                    out_hs;
  logic [CNT_W-1:0]        lane_cnt;

  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;
  assign out_hs   = out_valid & out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ctrl_t lane_ctrl;
    rv32_decode_lane u_dec (
      .inst (in_inst[32*g +: 32]),
      .ctrl (lane_ctrl)
    );
    assign in_ctrl[CTRL_W*g +: CTRL_W] = in_lane_vld[g] ? lane_ctrl : '0;
  end

  // Output register fed from skid first (older), else from the input; stalled accepts park in skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      in_ready      <= 1'b1;
      skid_vld      <= 1'b0;
      out_ctrl      <= '0;
      out_inst      <= '0;
      out_pc        <= '0;
      out_lane_vld  <= '0;
      skid_ctrl     <= '0;
      skid_inst     <= '0;
      skid_pc       <= '0;
      skid_lane_vld <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_vld  <= 1'b0;
      in_ready  <= 1'b1;
    end else if (out_free) begin
      in_ready <= 1'b1;
      if (skid_vld) begin
        out_valid    <= 1'b1;
        out_ctrl     <= skid_ctrl;
        out_inst     <= skid_inst;
        out_pc       <= skid_pc;
        out_lane_vld <= skid_lane_vld;
        skid_vld     <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        out_ctrl     <= in_ctrl;
        out_inst     <= in_inst;
        out_pc       <= in_pc;
        out_lane_vld <= in_lane_vld;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_vld      <= 1'b1;
      in_ready      <= 1'b0;
      skid_ctrl     <= in_ctrl;
      skid_inst     <= in_inst;
      skid_pc       <= in_pc;
      skid_lane_vld <= in_lane_vld;
    end
  end

  // Population count of valid lanes in the beat on the output.
  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_cnt = lane_cnt + CNT_W'(out_lane_vld[i]);
    end
  end

  // Delivered-lane counter; a flush cycle never counts even if out_ready is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_count <= '0;
    end else if (!flush && out_hs) begin
      dec_count <= dec_count + lane_cnt;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with LANES=2 (lane 1 masked off where a single lane is exercised).
// Each task drives one scenario and compares against hand-derived values, sampling 1ns after posedge.
// Expected counter values are tracked in exp_cnt from the number of valid lanes delivered.
module tb_decode_stage;
  import rv_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [63:0]       in_inst = '0;
  logic [63:0]       in_pc = '0;
  logic [1:0]        in_lane_vld = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2*CTRL_W-1:0] out_ctrl;
  logic [63:0]       out_inst;
  logic [63:0]       out_pc;
  logic [1:0]        out_lane_vld;
  logic [31:0]       dec_count;

  ctrl_t oc0, oc1;
  assign oc0 = out_ctrl[CTRL_W-1:0];
  assign oc1 = out_ctrl[2*CTRL_W-1:CTRL_W];

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] exp_cnt = '0;

  localparam logic [31:0] I_ADD = 32'h002081B3;

  decode_stage #(.LANES(2), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .in_lane_vld  (in_lane_vld),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_lane_vld (out_lane_vld),
    .dec_count    (dec_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [31:0] pc0, input logic [1:0] lv);
    in_valid    = v;
    in_inst     = {i1, i0};
    in_pc       = {pc0 + 32'd4, pc0};
    in_lane_vld = lv;
  endtask

  task automatic test_reset();
    step();
    step();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vecs++; if (dec_count !== 32'd0) begin errs++; $display("FAIL reset_dec_count: got %0d want 0", dec_count); end
    vecs++; if (out_ctrl !== '0) begin errs++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
    vecs++; if ({out_inst, out_pc, out_lane_vld} !== '0) begin errs++; $display("FAIL reset_payload: got %h %h %b want 0", out_inst, out_pc, out_lane_vld); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    put(1'b1, I_ADD, I_ADD, 32'h100, 2'b01);
    out_ready = 1'b1;
    step();
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
    vecs++; if (oc0.alu_op !== 5'b00000) begin errs++; $display("FAIL add_alu_op: got %b want 00000", oc0.alu_op); end
    vecs++; if (oc0.reg_write !== 1'b1) begin errs++; $display("FAIL add_reg_write: got %b want 1", oc0.reg_write); end
    vecs++; if (oc0.illegal !== 1'b0) begin errs++; $display("FAIL add_illegal: got %b want 0", oc0.illegal); end
    vecs++; if (oc1 !== ctrl_t'('0)) begin errs++; $display("FAIL add_lane1_zero: got %h want 0", oc1); end
    vecs++; if (out_pc[31:0] !== 32'h100) begin errs++; $display("FAIL add_pc: got %h want 100", out_pc[31:0]); end
    put(1'b0, I_ADD, I_ADD, 32'h0, 2'b00);
    step();
    exp_cnt = exp_cnt + 32'd1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL add_drain: got %b want 0", out_valid); end
    vecs++; if (dec_count !== exp_cnt) begin errs++; $display("FAIL add_count: got %0d want %0d", dec_count, exp_cnt); end
  endtask

  task automatic test_two_lanes();
    ctrl_t e0, e1;
    e0 = '0; e0.reg_write = 1'b1; e0.alu_op = 5'b00001;
    e1 = '0; e1.reg_write = 1'b1; e1.alu_src1 = 1'b1; e1.mem_read = 1'b1; e1.mem_to_reg = 1'b1;
    put(1'b1, 32'h40208133, 32'h0080A283, 32'h180, 2'b11);
    out_ready = 1'b1;
    step();
    vecs++; if (oc0 !== e0) begin errs++; $display("FAIL lanes2_sub: got %h want %h", oc0, e0); end
    vecs++; if (oc1 !== e1) begin errs++; $display("FAIL lanes2_lw: got %h want %h", oc1, e1); end
    vecs++; if (out_inst !== {32'h0080A283, 32'h40208133}) begin errs++; $display("FAIL lanes2_inst: got %h", out_inst); end
    put(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    step();
    exp_cnt = exp_cnt + 32'd2;
    vecs++; if (dec_count !== exp_cnt) begin errs++; $display("FAIL lanes2_count: got %0d want %0d", dec_count, exp_cnt); end
  endtask

  task automatic test_decode();
    logic [31:0] ins [21];
    ctrl_t       e   [21];
    for (int i = 0; i < 21; i++) e[i] = '0;
    ins[0]  = 32'h00000000; e[0].illegal = 1'b1;
    ins[1]  = 32'h0000307F; e[1].illegal = 1'b1;
    ins[2]  = 32'h00002063; e[2].illegal = 1'b1;
    ins[3]  = 32'h022081B3;
`ifdef RV32M_DECODE_EN
    e[3].reg_write = 1'b1; e[3].alu_op = 5'b10011;
`else
    e[3].illegal = 1'b1;
`endif
    ins[4]  = 32'h00007063; e[4].br = 6'b100000;
    ins[5]  = 32'h00005063; e[5].br = 6'b001000;
    ins[6]  = 32'h00004003; e[6].reg_write = 1'b1; e[6].alu_src1 = 1'b1; e[6].mem_read = 1'b1;
                            e[6].mem_to_reg = 1'b1; e[6].ls_byte = 1'b1; e[6].load_unsigned = 1'b1;
    ins[7]  = 32'h00001023; e[7].mem_write = 1'b1; e[7].alu_src1 = 1'b1; e[7].ls_half = 1'b1;
    ins[8]  = 32'h00003023; e[8].illegal = 1'b1;
    ins[9]  = 32'h40005013; e[9].reg_write = 1'b1; e[9].alu_src1 = 1'b1; e[9].alu_op = 5'b00111;
    ins[10] = 32'h40000013; e[10].reg_write = 1'b1; e[10].alu_src1 = 1'b1;
    ins[11] = 32'h000010B7; e[11].reg_write = 1'b1; e[11].alu_src1 = 1'b1; e[11].u_type = 1'b1; e[11].alu_op = 5'b01010;
    ins[12] = 32'h00001097; e[12].reg_write = 1'b1; e[12].alu_src0 = 1'b1; e[12].alu_src1 = 1'b1; e[12].u_type = 1'b1;
    ins[13] = 32'h0000006F; e[13].reg_write = 1'b1; e[13].jal = 1'b1;
    ins[14] = 32'h00000067; e[14].reg_write = 1'b1; e[14].jalr = 1'b1;
    ins[15] = 32'h00000073; e[15].ecall = 1'b1;
    ins[16] = 32'h00100073; e[16].ebreak = 1'b1;
    ins[17] = 32'h30200073; e[17].mret = 1'b1;
    ins[18] = 32'h30001073; e[18].illegal = 1'b1;
    ins[19] = 32'h042081B3; e[19].illegal = 1'b1;
    ins[20] = 32'h4020D1B3; e[20].reg_write = 1'b1; e[20].alu_op = 5'b00111;
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      put(1'b1, ins[i], 32'h00000013, 32'h1000 + 32'(i * 8), 2'b01);
      step();
      vecs++; if (oc0 !== e[i]) begin errs++; $display("FAIL decode[%0d] inst=%h: got %h want %h", i, ins[i], oc0, e[i]); end
    end
    put(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
    step();
    exp_cnt = exp_cnt + 32'd21;
    vecs++; if (dec_count !== exp_cnt) begin errs++; $display("FAIL decode_count: got %0d want %0d", dec_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    put(1'b1, I_ADD, I_ADD, 32'h200, 2'b11);
    out_ready = 1'b0;
    step();
    vecs++; if (out_valid !== 1'b1 || out_pc[31:0] !== 32'h200) begin errs++; $display("FAIL b2b_first: got v=%b pc=%h want v=1 pc=200", out_valid, out_pc[31:0]); end
    put(1'b1, I_ADD, I_ADD, 32'h300, 2'b11);
    step();
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b_skid_full: got in_ready=%b want 0", in_ready); end
    vecs++; if (out_pc[31:0] !== 32'h200) begin errs++; $display("FAIL b2b_hold: got pc=%h want 200", out_pc[31:0]); end
    put(1'b1, I_ADD, I_ADD, 32'h400, 2'b11);
    out_ready = 1'b1;
    step();
    vecs++; if (out_pc[31:0] !== 32'h300 || out_valid !== 1'b1) begin errs++; $display("FAIL b2b_second: got v=%b pc=%h want v=1 pc=300", out_valid, out_pc[31:0]); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_rise: got in_ready=%b want 1", in_ready); end
    step();
    vecs++; if (out_pc[31:0] !== 32'h400 || out_valid !== 1'b1) begin errs++; $display("FAIL b2b_third: got v=%b pc=%h want v=1 pc=400", out_valid, out_pc[31:0]); end
    put(1'b0, I_ADD, I_ADD, 32'h0, 2'b00);
    step();
    exp_cnt = exp_cnt + 32'd6;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_no_dup: got out_valid=%b want 0", out_valid); end
    vecs++; if (dec_count !== exp_cnt) begin errs++; $display("FAIL b2b_count: got %0d want %0d", dec_count, exp_cnt); end
  endtask

  task automatic test_flush();
    put(1'b1, I_ADD, I_ADD, 32'h500, 2'b11);
    out_ready = 1'b0;
    step();
    put(1'b1, I_ADD, I_ADD, 32'h600, 2'b11);
    step();
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_pre_full: got in_ready=%b want 0", in_ready); end
    put(1'b1, I_ADD, I_ADD, 32'h700, 2'b11);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    put(1'b0, I_ADD, I_ADD, 32'h0, 2'b00);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    vecs++; if (dec_count !== exp_cnt) begin errs++; $display("FAIL flush_count: got %0d want %0d", dec_count, exp_cnt); end
    step();
    vecs++; if (out_valid !== 1'b0 || dec_count !== exp_cnt) begin errs++; $display("FAIL flush_dropped: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, dec_count, exp_cnt); end
  endtask

  task automatic test_count_and_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 32'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, I_ADD, I_ADD, 32'h800 + 32'(i * 8), 2'b01);
      step();
      vecs++; if (oc1 !== ctrl_t'('0) || out_lane_vld !== 2'b01) begin errs++; $display("FAIL count_lane1[%0d]: got ctrl=%h vld=%b want 0/01", i, oc1, out_lane_vld); end
    end
    put(1'b0, I_ADD, I_ADD, 32'h0, 2'b00);
    step();
    exp_cnt = 32'd5;
    vecs++; if (dec_count !== exp_cnt) begin errs++; $display("FAIL count_five: got %0d want %0d", dec_count, exp_cnt); end
    out_ready = 1'b0;
    put(1'b1, I_ADD, I_ADD, 32'h900, 2'b01);
    step();
    put(1'b1, I_ADD, I_ADD, 32'hA00, 2'b01);
    step();
    put(1'b0, I_ADD, I_ADD, 32'h0, 2'b00);
    vecs++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL rst_pre_stall: got v=%b rdy=%b want 1/0", out_valid, in_ready); end
    #2;
    rst = 1'b1;
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1 || dec_count !== 32'd0) begin errs++; $display("FAIL rst_async_state: got rdy=%b cnt=%0d want 1/0", in_ready, dec_count); end
    vecs++; if (out_pc !== '0 || out_ctrl !== '0) begin errs++; $display("FAIL rst_async_payload: got pc=%h ctrl=%h want 0", out_pc, out_ctrl); end
    step();
    rst = 1'b0;
    step();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_release: got out_valid=%b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_two_lanes();
    test_decode();
    test_back_to_back();
    test_flush();
    test_count_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
